// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronises the serial line, aligns oversampling
// to the start edge, validates start/stop bits and deserialises LSB-first.
module uart_rx_sampler #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SAMP_W  = $clog2(OVERSAMPLE);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
   localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t                state;
   logic                  rx_s1;
   logic                  rx_s;
   logic                  rx_d;
   logic [DIV_W-1:0]      div_cnt;
   logic                  tick;
   logic [SAMP_W-1:0]     samp;
   logic [2:0]            bit_idx;
   logic [DATA_BITS-1:0]  shreg;
   logic                  start_det;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_s1 <= 1'b1;
         rx_s  <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s  <= rx_s1;
         rx_d  <= rx_s;
      end
   end

   // A start is only recognised on a high-to-low transition, so a line
   // stuck low (break) cannot retrigger reception.
   assign start_det = (state == IDLE) && rx_d && !rx_s;
   assign tick      = (div_cnt == DIV_LAST);

   // Oversampling tick divider, re-phased to the start edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
      end else if (start_det || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Frame FSM: mid-bit start validation, data shift, stop check, outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         samp      <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start_det) begin
                  state <= START;
                  samp  <= '0;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  if (samp == SAMP_MID) begin
                     if (rx_s) begin
                        // Line back high at mid-bit: treat as a glitch.
                        state <= IDLE;
                        busy  <= 1'b0;
                     end else begin
                        state   <= DATA;
                        samp    <= '0;
                        bit_idx <= '0;
                     end
                  end else begin
                     samp <= samp + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (samp == SAMP_LAST) begin
                     // Right shift: after the last bit the first one sits in the LSB.
                     shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                     samp  <= '0;
                     if (bit_idx == BIT_LAST) begin
                        state <= STOP;
                     end else begin
                        bit_idx <= bit_idx + 1'b1;
                     end
                  end else begin
                     samp <= samp + 1'b1;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (samp == SAMP_LAST) begin
                     if (rx_s) begin
                        rx_data   <= shreg;
                        rx_valid  <= 1'b1;
                        frame_err <= 1'b0;
                     end else begin
                        frame_err <= 1'b1;
                     end
                     state <= IDLE;
                     samp  <= '0;
                     busy  <= 1'b0;
                  end else begin
                     samp <= samp + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: directed scenarios plus a
// randomized frame stream checked against a frame-level reference model.
module tb_uart_rx_sampler;

   localparam int CLK_FREQ = 1600000;
   localparam int BAUD     = 100000;
   localparam int OVS      = 16;
   localparam int DBITS    = 8;
   localparam int BIT      = (CLK_FREQ / (BAUD * OVS)) * OVS;
   // Start edge to rx_valid: 1.5 bits to the first data centre, DBITS-1 more
   // data bits, one stop bit, plus synchroniser/edge/output register delay.
   localparam int LAT_EXP  = ((2 * DBITS + 3) * BIT) / 2 + 3;
   localparam int LAT_TOL  = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             rx  = 1'b1;
   logic [DBITS-1:0] rx_data;
   logic             rx_valid;
   logic             frame_err;
   logic             busy;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   int last_start = 0;

   logic [7:0] got_q[$];
   int         got_t[$];
   int         fe_events = 0;
   logic       fe_prev = 1'b0;

   uart_rx_sampler #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .OVERSAMPLE(OVS),
      .DATA_BITS (DBITS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every rx_valid pulse and every rising edge of frame_err.
   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         got_q.push_back(rx_data);
         got_t.push_back(cyc);
      end
      if (frame_err === 1'b1 && fe_prev !== 1'b1) fe_events <= fe_events + 1;
      fe_prev <= frame_err;
   end

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
      last_start = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < DBITS; i++) drive_bit(d[i]);
      drive_bit(stop);
      rx = 1'b1;
      repeat (gap * BIT) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %0h, expected 0", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %0b, expected 0", rx_valid); end
      checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %0b, expected 0", frame_err); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
      rst = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %0b, expected 0", busy); end
   endtask

   task automatic test_single();
      int n0;
      int t0;
      int lat;
      logic [7:0] d0;
      n0 = got_q.size();
      send_frame(8'hA5, 1'b1, 0);
      t0 = last_start;
      repeat (2 * BIT) @(negedge clk);
      d0  = (got_q.size() > n0) ? got_q[n0] : 8'hxx;
      lat = (got_q.size() > n0) ? got_t[n0] - t0 : -1;
      checks++; if (got_q.size() - n0 !== 1) begin fails++; $display("FAIL single_pulses: got %0d, expected 1", got_q.size() - n0); end
      checks++; if (d0 !== 8'hA5) begin fails++; $display("FAIL single_data: got %0h, expected a5", d0); end
      checks++; if (lat < LAT_EXP - LAT_TOL || lat > LAT_EXP + LAT_TOL) begin fails++; $display("FAIL single_latency: got %0d, expected %0d+-%0d", lat, LAT_EXP, LAT_TOL); end
      checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL single_frame_err: got %0b, expected 0", frame_err); end
   endtask

   task automatic test_back_to_back();
      int n0;
      int sp;
      logic [7:0] d0;
      logic [7:0] d1;
      n0 = got_q.size();
      send_frame(8'h00, 1'b1, 0);
      send_frame(8'hFF, 1'b1, 2);
      d0 = (got_q.size() > n0)     ? got_q[n0]     : 8'hxx;
      d1 = (got_q.size() > n0 + 1) ? got_q[n0 + 1] : 8'hxx;
      sp = (got_q.size() > n0 + 1) ? got_t[n0 + 1] - got_t[n0] : -1;
      checks++; if (got_q.size() - n0 !== 2) begin fails++; $display("FAIL b2b_pulses: got %0d, expected 2", got_q.size() - n0); end
      checks++; if (d0 !== 8'h00) begin fails++; $display("FAIL b2b_data0: got %0h, expected 00", d0); end
      checks++; if (d1 !== 8'hFF) begin fails++; $display("FAIL b2b_data1: got %0h, expected ff", d1); end
      checks++; if (sp < 10 * BIT - 2 || sp > 10 * BIT + 2) begin fails++; $display("FAIL b2b_spacing: got %0d, expected %0d+-2", sp, 10 * BIT); end
   endtask

   task automatic test_glitch();
      int n0;
      int busy_cnt;
      logic [7:0] prev;
      n0 = got_q.size();
      prev = rx_data;
      busy_cnt = 0;
      rx = 1'b0;
      repeat (5) begin @(negedge clk); if (busy === 1'b1) busy_cnt++; end
      rx = 1'b1;
      repeat (40) begin @(negedge clk); if (busy === 1'b1) busy_cnt++; end
      checks++; if (busy_cnt < 1 || busy_cnt > 12) begin fails++; $display("FAIL glitch_busy_cycles: got %0d, expected 1..12", busy_cnt); end
      checks++; if (got_q.size() - n0 !== 0) begin fails++; $display("FAIL glitch_pulses: got %0d, expected 0", got_q.size() - n0); end
      checks++; if (rx_data !== prev) begin fails++; $display("FAIL glitch_rx_data: got %0h, expected %0h", rx_data, prev); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_end: got %0b, expected 0", busy); end
   endtask

   task automatic test_frame_error();
      int n0;
      logic [7:0] prev;
      logic [7:0] d0;
      n0 = got_q.size();
      prev = rx_data;
      send_frame(8'h3C, 1'b0, 1);
      checks++; if (got_q.size() - n0 !== 0) begin fails++; $display("FAIL ferr_pulses: got %0d, expected 0", got_q.size() - n0); end
      checks++; if (frame_err !== 1'b1) begin fails++; $display("FAIL ferr_flag: got %0b, expected 1", frame_err); end
      checks++; if (rx_data !== prev) begin fails++; $display("FAIL ferr_rx_data: got %0h, expected %0h", rx_data, prev); end
      n0 = got_q.size();
      send_frame(8'h55, 1'b1, 1);
      d0 = (got_q.size() > n0) ? got_q[n0] : 8'hxx;
      checks++; if (got_q.size() - n0 !== 1) begin fails++; $display("FAIL recover_pulses: got %0d, expected 1", got_q.size() - n0); end
      checks++; if (d0 !== 8'h55) begin fails++; $display("FAIL recover_data: got %0h, expected 55", d0); end
      checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL recover_frame_err: got %0b, expected 0", frame_err); end
   endtask

   task automatic test_break();
      int n0;
      int fe0;
      int busy_after;
      n0 = got_q.size();
      fe0 = fe_events;
      rx = 1'b0;
      repeat (30 * BIT) @(negedge clk);
      rx = 1'b1;
      busy_after = 0;
      repeat (5 * BIT) begin @(negedge clk); if (busy === 1'b1) busy_after++; end
      checks++; if (fe_events - fe0 !== 1) begin fails++; $display("FAIL break_err_events: got %0d, expected 1", fe_events - fe0); end
      checks++; if (got_q.size() - n0 !== 0) begin fails++; $display("FAIL break_pulses: got %0d, expected 0", got_q.size() - n0); end
      checks++; if (frame_err !== 1'b1) begin fails++; $display("FAIL break_frame_err: got %0b, expected 1", frame_err); end
      checks++; if (busy_after !== 0) begin fails++; $display("FAIL break_no_refire: got %0d busy cycles, expected 0", busy_after); end
   endtask

   task automatic test_reset_mid();
      int n0;
      logic [7:0] d0;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b0);
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy_before: got %0b, expected 1", busy); end
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL rstmid_rx_data: got %0h, expected 0", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL rstmid_rx_valid: got %0b, expected 0", rx_valid); end
      checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL rstmid_frame_err: got %0b, expected 0", frame_err); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %0b, expected 0", busy); end
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      n0 = got_q.size();
      send_frame(8'h81, 1'b1, 2);
      d0 = (got_q.size() > n0) ? got_q[n0] : 8'hxx;
      checks++; if (got_q.size() - n0 !== 1) begin fails++; $display("FAIL rstmid_after_pulses: got %0d, expected 1", got_q.size() - n0); end
      checks++; if (d0 !== 8'h81) begin fails++; $display("FAIL rstmid_after_data: got %0h, expected 81", d0); end
      checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL rstmid_after_frame_err: got %0b, expected 0", frame_err); end
   endtask

   task automatic test_random();
      int         n0;
      logic [7:0] exp_q[$];
      int         exp_t[$];
      logic [7:0] d;
      logic       stop;
      int         gap;
      logic [7:0] g;
      int         lat;
      n0 = got_q.size();
      for (int f = 0; f < 10; f++) begin
         d    = 8'($urandom_range(0, 255));
         stop = (f == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         // A low stop bit needs an idle bit before the next start edge can be seen.
         gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
         send_frame(d, stop, 0);
         if (stop) begin
            exp_q.push_back(d);
            exp_t.push_back(last_start);
         end
         checks++; if (frame_err !== !stop) begin fails++; $display("FAIL rand_frame_err[%0d]: got %0b, expected %0b", f, frame_err, !stop); end
         repeat (gap * BIT) @(negedge clk);
      end
      repeat (2 * BIT) @(negedge clk);
      checks++; if (got_q.size() - n0 !== exp_q.size()) begin fails++; $display("FAIL rand_pulses: got %0d, expected %0d", got_q.size() - n0, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         g   = (got_q.size() > n0 + i) ? got_q[n0 + i] : 8'hxx;
         lat = (got_q.size() > n0 + i) ? got_t[n0 + i] - exp_t[i] : -1;
         checks++; if (g !== exp_q[i]) begin fails++; $display("FAIL rand_data[%0d]: got %0h, expected %0h", i, g, exp_q[i]); end
         checks++; if (lat < LAT_EXP - LAT_TOL || lat > LAT_EXP + LAT_TOL) begin fails++; $display("FAIL rand_latency[%0d]: got %0d, expected %0d+-%0d", i, lat, LAT_EXP, LAT_TOL); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_error();
      test_break();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
